// File: rtl/bitstream_counter.sv
// rtl/bitstream_counter.sv - counts ones in a stochastic bitstream over a fixed window after a warm-up skip
module bitstream_counter #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 255,
  parameter int SKIP   = 5
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_in,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] value
);

  typedef enum logic [1:0] {IDLE, WARMUP, COUNT, DONE} state_t;

  // Down-counters hold "cycles remaining minus one", so zero marks the last cycle of a state.
  localparam logic [7:0]       SKIP_LOAD = (SKIP == 0) ? 8'd0 : 8'(SKIP - 1);
  localparam logic [WIDTH-1:0] WIN_LOAD  = WIDTH'(WINDOW - 1);

  state_t           state, state_nxt;
  logic [7:0]       warm_cnt;
  logic [WIDTH-1:0] win_cnt;
  logic [WIDTH-1:0] ones_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = (SKIP == 0) ? COUNT : WARMUP;
        WARMUP:  if (warm_cnt == 8'd0) state_nxt = COUNT;
        COUNT:   if (win_cnt == '0) state_nxt = DONE;
        DONE:    if (ack) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = (state == WARMUP) || (state == COUNT);
    valid = (state == DONE);
    value = ones_cnt;
  end

  // Abort freezes the counters; the next start reloads them, so no partial count carries over.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      warm_cnt <= 8'd0;
      win_cnt  <= '0;
      ones_cnt <= '0;
    end else if (!abort) begin
      case (state)
        IDLE: begin
          if (start) begin
            ones_cnt <= '0;
            if (SKIP == 0) win_cnt  <= WIN_LOAD;
            else           warm_cnt <= SKIP_LOAD;
          end
        end
        WARMUP: begin
          if (warm_cnt == 8'd0) win_cnt  <= WIN_LOAD;
          else                  warm_cnt <= warm_cnt - 8'd1;
        end
        COUNT: begin
          ones_cnt <= ones_cnt + WIDTH'(bit_in);
          if (win_cnt != '0) win_cnt <= win_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_counter.sv
// tb/tb_bitstream_counter.sv - directed bench for bitstream_counter (default and SKIP=0/WINDOW=4 builds)
module tb_bitstream_counter;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start, abort, bit_in, ack;
  logic       busy, valid;
  logic [7:0] value;
  logic       s0_start, s0_abort, s0_bit_in, s0_ack;
  logic       s0_busy, s0_valid;
  logic [7:0] s0_value;
  int         tests  = 0;
  int         failed = 0;

  always #5 clk = ~clk;

  bitstream_counter dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .bit_in(bit_in),
    .ack(ack), .busy(busy), .valid(valid), .value(value)
  );

  bitstream_counter #(.WIDTH(8), .WINDOW(4), .SKIP(0)) dut_s0 (
    .clk(clk), .n_rst(n_rst), .start(s0_start), .abort(s0_abort), .bit_in(s0_bit_in),
    .ack(s0_ack), .busy(s0_busy), .valid(s0_valid), .value(s0_value)
  );

  // Caller is at the negedge of cycle 0; returns at the negedge of cycle 261 (first DONE cycle).
  // pat: 0 all zeros, 1 all ones, 2 ones only in cycles 1..5, 3 ones on odd cycles.
  task automatic conv(input int pat, input int exp_val, input int pulse_c);
    start  = 1'b1;
    bit_in = 1'b0;
    for (int c = 1; c <= 261; c++) begin
      @(negedge clk);
      start = (c == pulse_c);
      case (pat)
        0:       bit_in = 1'b0;
        1:       bit_in = 1'b1;
        2:       bit_in = (c <= 5);
        default: bit_in = c[0];
      endcase
      if (c <= 260) begin
        tests++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
          failed++;
          $display("FAIL conv_busy pat=%0d cycle=%0d busy=%b valid=%b expected busy=1 valid=0", pat, c, busy, valid);
        end
      end else begin
        tests++;
        if (valid !== 1'b1 || busy !== 1'b0) begin
          failed++;
          $display("FAIL conv_done pat=%0d cycle=%0d busy=%b valid=%b expected busy=0 valid=1", pat, c, busy, valid);
        end
        tests++;
        if (value !== 8'(exp_val)) begin
          failed++;
          $display("FAIL conv_value pat=%0d got=%0d expected=%0d", pat, value, exp_val);
        end
      end
    end
    start  = 1'b0;
    bit_in = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    tests++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL ack_idle valid=%b busy=%b expected 0 0", valid, busy);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    start = 0; abort = 0; bit_in = 0; ack = 0;
    s0_start = 0; s0_abort = 0; s0_bit_in = 0; s0_ack = 0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || valid !== 1'b0 || value !== 8'd0) begin
      failed++;
      $display("FAIL reset_state busy=%b valid=%b value=%0d expected 0 0 0", busy, valid, value);
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_patterns();
    conv(1, 255, 0); do_ack();
    tests++;
    if (value !== 8'd255) begin
      failed++;
      $display("FAIL value_retained got=%0d expected=255", value);
    end
    conv(0, 0, 0);   do_ack();
    conv(2, 0, 0);   do_ack();
    conv(3, 127, 0); do_ack();
  endtask

  task automatic test_skip0();
    s0_start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      s0_start  = 1'b0;
      s0_bit_in = (c != 3) && (c <= 4);
      if (c <= 4) begin
        tests++;
        if (s0_busy !== 1'b1 || s0_valid !== 1'b0) begin
          failed++;
          $display("FAIL skip0_busy cycle=%0d busy=%b valid=%b expected 1 0", c, s0_busy, s0_valid);
        end
      end else begin
        tests++;
        if (s0_valid !== 1'b1 || s0_value !== 8'd3) begin
          failed++;
          $display("FAIL skip0_done valid=%b value=%0d expected valid=1 value=3", s0_valid, s0_value);
        end
      end
    end
    s0_bit_in = 1'b0;
    s0_ack = 1'b1;
    @(negedge clk);
    s0_ack = 1'b0;
    tests++;
    if (s0_valid !== 1'b0 || s0_value !== 8'd3) begin
      failed++;
      $display("FAIL skip0_ack valid=%b value=%0d expected valid=0 value=3", s0_valid, s0_value);
    end
  endtask

  task automatic test_hold();
    conv(3, 127, 100);
    for (int c = 262; c <= 300; c++) begin
      @(negedge clk);
      tests++;
      if (valid !== 1'b1 || value !== 8'd127) begin
        failed++;
        $display("FAIL hold cycle=%0d valid=%b value=%0d expected valid=1 value=127", c, valid, value);
      end
    end
    ack = 1'b1; start = 1'b1;
    @(negedge clk);
    ack = 1'b0; start = 1'b0;
    tests++;
    if (valid !== 1'b0 || busy !== 1'b0 || value !== 8'd127) begin
      failed++;
      $display("FAIL ack_with_start valid=%b busy=%b value=%0d expected 0 0 127", valid, busy, value);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL start_in_done_ignored busy=%b expected 0", busy);
    end
  endtask

  task automatic test_abort();
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    tests++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      failed++;
      $display("FAIL abort_idle_start busy=%b valid=%b expected 0 0", busy, valid);
    end
    start = 1'b1; bit_in = 1'b1;
    for (int c = 1; c <= 110; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (c == 100);
      if (c >= 101) begin
        tests++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
          failed++;
          $display("FAIL abort_count cycle=%0d busy=%b valid=%b expected 0 0", c, busy, valid);
        end
      end
    end
    abort = 1'b0;
    conv(1, 255, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL abort_done valid=%b busy=%b expected 0 0", valid, busy);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; bit_in = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 n_rst = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || valid !== 1'b0 || value !== 8'd0) begin
      failed++;
      $display("FAIL async_reset busy=%b valid=%b value=%0d expected 0 0 0", busy, valid, value);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    conv(1, 255, 0);
    do_ack();
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_skip0();
    test_hold();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
